// File: rtl/system_led_out_if.sv
// Avalon-MM slave bus bundle for the LED output port.
// The master side (interconnect / testbench) drives the request signals
// and samples the registered read data returned by the slave.
interface system_led_out_if;
    logic        chipselect;
    logic [1:0]  address;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output chipselect,
        output address,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  chipselect,
        input  address,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/system_led_out.sv
// LED output port on the Nios II Avalon-MM interconnect.
// Software writes DATA directly or sets/clears individual bits through SETCLR.
// Bits selected in BLINK_MASK are forced low during the "off" half of a
// hardware blink, whose half-period is BLINK_PERIOD ticks of PRESCALE clocks.
// Every register reads back through a one-cycle registered read path.
module system_led_out #(
    parameter int                 WIDTH       = 8,
    parameter int                 PRESCALE    = 50000,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    system_led_out_if.slave  bus,
    output logic [WIDTH-1:0] out_port
);

    localparam int              PCNT_W   = $clog2(PRESCALE);
    localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(PRESCALE - 1);

    logic [WIDTH-1:0]  data_reg;
    logic [WIDTH-1:0]  blink_mask;
    logic [15:0]       blink_period;
    logic [PCNT_W-1:0] pcnt;
    logic [15:0]       tcnt;
    logic              phase;

    logic              write_en;
    logic              period_write;
    logic              tick;
    logic              tcnt_wrap;
    logic [WIDTH-1:0]  set_bits;
    logic [WIDTH-1:0]  clr_bits;
    logic              unused_wdata;

    assign write_en     = bus.chipselect & ~bus.write_n;
    assign period_write = write_en && (bus.address == 2'd2);
    assign tick         = (pcnt == PCNT_MAX);
    assign tcnt_wrap    = (tcnt == blink_period - 16'd1);
    assign set_bits     = bus.writedata[WIDTH-1:0];
    assign clr_bits     = bus.writedata[WIDTH+7:8];
    assign unused_wdata = ^bus.writedata;

    // Software-visible registers; SETCLR applies the clear after the set so clear wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg     <= RESET_VALUE;
            blink_mask   <= '0;
            blink_period <= '0;
        end else if (write_en) begin
            case (bus.address)
                2'd0:    data_reg     <= bus.writedata[WIDTH-1:0];
                2'd1:    blink_mask   <= bus.writedata[WIDTH-1:0];
                2'd2:    blink_period <= bus.writedata[15:0];
                default: data_reg     <= (data_reg | set_bits) & ~clr_bits;
            endcase
        end
    end

    // Blink timebase: prescaler feeds the tick counter, which toggles phase every BLINK_PERIOD ticks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcnt  <= '0;
            tcnt  <= '0;
            phase <= 1'b0;
        end else if (period_write || (blink_period == 16'd0)) begin
            pcnt  <= '0;
            tcnt  <= '0;
            phase <= 1'b0;
        end else if (tick) begin
            pcnt <= '0;
            if (tcnt_wrap) begin
                tcnt  <= '0;
                phase <= ~phase;
            end else begin
                tcnt <= tcnt + 16'd1;
            end
        end else begin
            pcnt <= pcnt + PCNT_W'(1);
        end
    end

    // LED drive: masked bits are forced low while phase is in its "off" half.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_port <= RESET_VALUE;
        end else begin
            out_port <= data_reg & ~(blink_mask & {WIDTH{phase}});
        end
    end

    // Read path: one cycle of latency, zero when not selected, no side effects.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= '0;
        end else if (bus.chipselect) begin
            case (bus.address)
                2'd0:    bus.readdata <= 32'(data_reg);
                2'd1:    bus.readdata <= 32'(blink_mask);
                2'd2:    bus.readdata <= 32'(blink_period);
                default: bus.readdata <= 32'(out_port);
            endcase
        end else begin
            bus.readdata <= '0;
        end
    end

endmodule

// File: tb/tb_system_led_out.sv
// Self-checking bench for system_led_out.
// A behavioural model derives the blink phase from the number of clock edges
// since BLINK_PERIOD was last written; directed sequences pin hand-computed values.
module tb_system_led_out;

    localparam int             W  = 8;
    localparam int             PS = 4;
    localparam logic [W-1:0]   RV = 8'h00;

    logic         clk     = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] out_port;
    bit           check_en = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m_data    = RV;
    logic [W-1:0] m_mask    = '0;
    logic [15:0]  m_period  = '0;
    int           m_elapsed = 0;
    logic [W-1:0] exp_out   = RV;
    logic [31:0]  exp_rd    = '0;

    system_led_out_if bus_if ();

    system_led_out #(
        .WIDTH       (W),
        .PRESCALE    (PS),
        .RESET_VALUE (RV)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus_if),
        .out_port (out_port)
    );

    always #5 clk = ~clk;

    // Compares one DUT value against its expected value and keeps the tallies.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h, want %h", name, $time, actual, expected);
        end
    endtask

    // Drives one bus cycle, changing inputs on the falling edge.
    task automatic applyStimulus(input logic cs, input logic wn, input logic [1:0] addr, input logic [31:0] wd);
        @(negedge clk);
        bus_if.chipselect = cs;
        bus_if.write_n    = wn;
        bus_if.address    = addr;
        bus_if.writedata  = wd;
    endtask

    task automatic writeReg(input logic [1:0] addr, input logic [31:0] wd);
        applyStimulus(1'b1, 1'b0, addr, wd);
        applyStimulus(1'b0, 1'b1, 2'd0, 32'h0);
    endtask

    task automatic readReg(input logic [1:0] addr, output logic [31:0] val);
        applyStimulus(1'b1, 1'b1, addr, 32'h0);
        @(posedge clk);
        #1;
        val = bus_if.readdata;
        applyStimulus(1'b0, 1'b1, 2'd0, 32'h0);
    endtask

    // Blink phase from elapsed edges since the last BLINK_PERIOD write.
    function automatic logic modelPhase();
        if (m_period == 16'd0) return 1'b0;
        return ((m_elapsed / (int'(m_period) * PS)) % 2) == 1;
    endfunction

    // Behavioural model: register file, derived phase, and one-cycle output/read latency.
    always @(posedge clk or negedge reset_n) begin
        logic [31:0]  rd;
        logic [W-1:0] nxt;
        if (!reset_n) begin
            m_data    = RV;
            m_mask    = '0;
            m_period  = '0;
            m_elapsed = 0;
            exp_out   = RV;
            exp_rd    = '0;
        end else begin
            nxt = m_data & ~(m_mask & {W{modelPhase()}});
            case (bus_if.address)
                2'd0:    rd = 32'(m_data);
                2'd1:    rd = 32'(m_mask);
                2'd2:    rd = 32'(m_period);
                default: rd = 32'(exp_out);
            endcase
            exp_rd  = bus_if.chipselect ? rd : 32'h0;
            exp_out = nxt;
            m_elapsed++;
            if (bus_if.chipselect && !bus_if.write_n) begin
                case (bus_if.address)
                    2'd0: m_data = bus_if.writedata[W-1:0];
                    2'd1: m_mask = bus_if.writedata[W-1:0];
                    2'd2: begin
                        m_period  = bus_if.writedata[15:0];
                        m_elapsed = 0;
                    end
                    default: m_data = (m_data | bus_if.writedata[W-1:0]) & ~bus_if.writedata[W+7:8];
                endcase
            end
        end
    end

    // Every cycle out of reset, DUT outputs must match the model.
    always @(posedge clk) begin
        #1;
        if (check_en && reset_n) begin
            checkOutput("model_out", 32'(out_port), 32'(exp_out));
            checkOutput("model_rd", bus_if.readdata, exp_rd);
        end
    end

    // Directed sequences followed by randomized traffic.
    initial begin
        logic [31:0] val;
        logic        cs;
        logic        wn;
        logic [1:0]  addr;
        logic [31:0] wd;

        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.address    = 2'd0;
        bus_if.writedata  = 32'h0;
        repeat (3) @(negedge clk);
        reset_n  = 1'b1;
        check_en = 1'b1;

        for (int a = 0; a < 4; a++) begin
            readReg(2'(a), val);
            checkOutput("reset_read", val, 32'h0);
        end
        checkOutput("reset_out", 32'(out_port), 32'h00);

        writeReg(2'd0, 32'h1A5);
        checkOutput("data_out_write_edge", 32'(out_port), 32'h00);
        @(posedge clk);
        #1;
        checkOutput("data_out_next_edge", 32'(out_port), 32'hA5);
        readReg(2'd0, val);
        checkOutput("data_readback", val, 32'h0000_00A5);

        writeReg(2'd0, 32'hF0);
        writeReg(2'd3, 32'h0000_3003);
        readReg(2'd0, val);
        checkOutput("setclr_c3", val, 32'hC3);
        writeReg(2'd3, 32'h0000_0101);
        readReg(2'd0, val);
        checkOutput("setclr_clear_wins", val, 32'hC2);

        writeReg(2'd0, 32'hFF);
        writeReg(2'd1, 32'h0F);
        applyStimulus(1'b1, 1'b0, 2'd2, 32'd3);
        @(posedge clk);
        #1;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        for (int k = 1; k <= 37; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("blink_k%0d", k), 32'(out_port),
                        ((k >= 13 && k <= 24) || k >= 37) ? 32'hF0 : 32'hFF);
        end

        writeReg(2'd2, 32'd0);
        checkOutput("stop_write_edge", 32'(out_port), 32'hF0);
        @(posedge clk);
        #1;
        checkOutput("stop_restore", 32'(out_port), 32'hFF);
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            checkOutput("stop_steady", 32'(out_port), 32'hFF);
        end
        readReg(2'd2, val);
        checkOutput("period_zero_read", val, 32'h0);

        writeReg(2'd2, 32'd2);
        repeat (20) @(posedge clk);
        applyStimulus(1'b1, 1'b1, 2'd0, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("pre_reset_read", bus_if.readdata, 32'hFF);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset_out", 32'(out_port), 32'(RV));
        checkOutput("async_reset_rd", bus_if.readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        bus_if.chipselect = 1'b0;
        writeReg(2'd0, 32'hFF);
        writeReg(2'd1, 32'h0F);
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            checkOutput("no_blink_after_reset", 32'(out_port), 32'hFF);
        end

        for (int i = 0; i < 3000; i++) begin
            cs   = ($urandom_range(0, 9) != 0);
            wn   = ($urandom_range(0, 2) != 0);
            addr = 2'($urandom_range(0, 3));
            wd   = $urandom;
            if (addr == 2'd2 && !wn) begin
                if ($urandom_range(0, 7) != 0) begin
                    wn = 1'b1;
                end else begin
                    wd[15:0] = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 3));
                end
            end
            applyStimulus(cs, wn, addr, wd);
        end
        applyStimulus(1'b0, 1'b1, 2'd0, 32'h0);
        repeat (5) @(posedge clk);
        #2;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/system_led_out.md
# system_led_out

Avalon-MM slave output port that drives the board LEDs from the Nios II system; it is the write-direction counterpart of the switch input port on the same interconnect. Software writes an output value, atomically sets or clears individual bits, and can make selected bits blink at a programmable rate without CPU involvement. All registers read back through a zero-wait-state registered read path.

## Interface

- WIDTH, 8: number of output bits.
- PRESCALE, 50000: clk cycles per blink tick (1 ms at 50 MHz); must be ≥ 2.
- RESET_VALUE, 0: value of DATA and out_port after reset.

- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- chipselect  in  1  slave selected.
- address  in  2  register word address.
- write_n  in  1  active-low write strobe; a write takes effect only when chipselect=1 and write_n=0.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- out_port  out  WIDTH  registered LED drive.

## Operation

- Register map:
  - 0 DATA: R/W, bits [WIDTH-1:0].
  - 1 BLINK_MASK: R/W, bits [WIDTH-1:0]. A 1 marks that bit as blinking.
  - 2 BLINK_PERIOD: R/W, bits [15:0]. Half-period in ticks; 0 disables blinking.
  - 3 SETCLR:
    - Write: DATA <= (DATA | writedata[WIDTH-1:0]) & ~writedata[WIDTH+7:8].
    - Read: returns current out_port.
- Unused writedata bits are ignored. Unused readdata bits read 0.
- Write to any address with writedata = 0 on ignored bits has no side effects beyond the register named.
- Prescaler (pcnt) counts 0..PRESCALE-1 and wraps.
  - tick = (pcnt == PRESCALE-1).
  - pcnt runs only while BLINK_PERIOD ≠ 0; otherwise it is held at 0.
- Tick counter (tcnt):
  - On tick: if tcnt == BLINK_PERIOD-1, tcnt <= 0 and phase toggles; else tcnt increments.
  - tcnt is 16 bits and never exceeds BLINK_PERIOD-1.
- phase is held 0 while BLINK_PERIOD = 0.
- Any write to BLINK_PERIOD clears pcnt, tcnt and phase in the same cycle as the write.
- Output function: out_port <= DATA & ~(BLINK_MASK & {WIDTH{phase}}). During the "off" phase, masked bits are forced to 0.
- Writing BLINK_MASK does not disturb the counters.
- Simultaneous set and clear of the same bit via SETCLR: clear wins.
- Reads have no side effects; read_n is not used.

## Timing

- Reset values:
  - DATA = RESET_VALUE; BLINK_MASK = 0; BLINK_PERIOD = 0.
  - pcnt = tcnt = phase = 0.
  - out_port = RESET_VALUE; readdata = 0.
- Reset is asynchronous assert and synchronous deassert (external synchronizer). Asserting reset mid-blink returns everything to reset values immediately.
- Write latency:
  - A write sampled at rising edge N updates the register at edge N.
  - out_port reflects the new value after edge N+1.
- Read path:
  - readdata is updated every cycle from the address sampled at that edge, gated by chipselect=1; it holds 0 otherwise.
  - Data is valid the cycle after address is presented (Avalon read latency 1, zero wait states).
  - A read of a register written at edge N returns the new value when sampled at edge N+1 or later.
- Blink timing:
  - With BLINK_PERIOD = P ≠ 0 written at edge N, the first phase toggle occurs at edge N + P·PRESCALE.
  - Subsequent toggles occur every P·PRESCALE cycles.
  - out_port follows each toggle by one cycle.
- Changing BLINK_PERIOD from P to 0 while phase = 1 forces phase to 0 at the write edge. Masked bits restore on out_port one cycle later.
- Write with chipselect=0 or write_n=1 is ignored.

## Test plan

- Reset, then read all four addresses:
  - RESET_VALUE=0x00 → readdata 0x0, 0x0, 0x0, 0x0; out_port = 0x00.
- Write DATA=0x1A5 (WIDTH=8):
  - readback = 0x000000A5; out_port = 0xA5 exactly one cycle after the write edge.
- Start with DATA=0xF0, then write SETCLR=0x0000_3003:
  - DATA = 0xC3; readback at address 0 = 0xC3.
  - Then SETCLR=0x0000_0101: bit0 set and cleared, clear wins → DATA = 0xC2.
- Blink setup: PRESCALE=4, DATA=0xFF, MASK=0x0F, PERIOD=3 written at edge N:
  - out_port = 0xFF until edge N+12, becomes 0xF0 at N+13, returns to 0xFF at N+25.
- Mid-blink PERIOD=0 while out_port = 0xF0:
  - out_port = 0xFF one cycle later and stays constant for ≥ 100 cycles.
- Assert reset_n low mid-blink for 1 cycle:
  - out_port = RESET_VALUE and readdata = 0 immediately (asynchronous).
  - No toggles after release until PERIOD is rewritten.
